// File: rtl/dsp_mac_signed_pipe.sv
// dsp_mac_signed_pipe: three-stage pipelined signed multiply-accumulate with optional saturation
// Ports: clk       single clock, active edge chosen by NEG_EDGE
//        reset     synchronous active-high reset
//        in_valid  qualifies A, B and mode on the active edge
//        mode      0 MUL, 1 ACC, 2 SUB, 3 CLR
//        A, B      signed operands
//        out_valid single-cycle pulse per valid sample
//        P         signed result, which is the accumulator register itself
//        ovf       the result on P overflowed ACC_WIDTH
module dsp_mac_signed_pipe #(
    parameter int A_WIDTH   = 20,
    parameter int B_WIDTH   = 18,
    parameter int ACC_WIDTH = 48,
    parameter bit SATURATE  = 1'b0,
    parameter bit NEG_EDGE  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [1:0]           mode,
    input  logic [A_WIDTH-1:0]   A,
    input  logic [B_WIDTH-1:0]   B,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] P,
    output logic                 ovf
);
    localparam int PW = A_WIDTH + B_WIDTH;
    if (ACC_WIDTH < PW) begin : g_width_check
        $error("dsp_mac_signed_pipe: ACC_WIDTH must be >= A_WIDTH+B_WIDTH");
    end
    typedef struct packed {
        logic [A_WIDTH-1:0]   a;
        logic [B_WIDTH-1:0]   b;
        logic [1:0]           m1;
        logic                 v1;
        logic [PW-1:0]        prod;
        logic [1:0]           m2;
        logic                 v2;
        logic [ACC_WIDTH-1:0] acc;
        logic                 ovf;
        logic                 vo;
    } pipe_t;
    pipe_t q, d;
    logic signed [PW-1:0]        ax, bx;
    logic signed [ACC_WIDTH:0]   pe, ae, sum;
    logic                        ov;
    // One extra bit of headroom: overflow shows up as the top two bits disagreeing.
    always_comb begin
        ax = PW'($signed(q.a));
        bx = PW'($signed(q.b));
        pe = (ACC_WIDTH+1)'($signed(q.prod));
        ae = (ACC_WIDTH+1)'($signed(q.acc));
        sum = q.m2 == 2'd2 ? ae - pe : ae + pe;
        ov = (q.m2[1] ^ q.m2[0]) & (sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1]);
        d.a = A;
        d.b = B;
        d.m1 = mode;
        d.v1 = in_valid;
        d.prod = ax * bx;
        d.m2 = q.m1;
        d.v2 = q.v1;
        d.vo = q.v2;
        d.ovf = q.v2 ? ov : q.ovf;
        d.acc = !q.v2 ? q.acc :
                q.m2 == 2'd3 ? '0 :
                q.m2 == 2'd0 ? pe[ACC_WIDTH-1:0] :
                (ov && SATURATE) ? {sum[ACC_WIDTH], {(ACC_WIDTH-1){~sum[ACC_WIDTH]}}} :
                sum[ACC_WIDTH-1:0];
    end
    if (NEG_EDGE) begin : g_neg
        always_ff @(negedge clk) q <= reset ? '0 : d;
    end else begin : g_pos
        always_ff @(posedge clk) q <= reset ? '0 : d;
    end
    assign P = q.acc;
    assign ovf = q.ovf;
    assign out_valid = q.vo;
endmodule

// File: tb/tb_dsp_mac_signed_pipe.sv
// tb_dsp_mac_signed_pipe: checks default, 38-bit saturating and 38-bit wrapping MACs against an arithmetic model
module tb_dsp_mac_signed_pipe;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [19:0] A = '0;
    logic [17:0] B = '0;
    logic [2:0]  vo, fo;
    logic [47:0] P0;
    logic [37:0] P1, P2;
    logic signed [63:0] pobs [3];
    int checks = 0;
    int errors = 0;
    typedef struct packed {
        logic            v;
        logic [2:0]      o;
        logic [2:0][63:0] p;
    } ent_t;
    ent_t   sb[$];
    longint macc [3];
    logic   movf [3];
    int     wid [3] = '{48, 38, 38};
    bit     sat [3] = '{1'b0, 1'b1, 1'b0};
    always #5 clk = ~clk;
    dsp_mac_signed_pipe dut_d (
        .clk(clk), .reset(reset), .in_valid(in_valid), .mode(mode), .A(A), .B(B),
        .out_valid(vo[0]), .P(P0), .ovf(fo[0])
    );
    dsp_mac_signed_pipe #(.ACC_WIDTH(38), .SATURATE(1'b1)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .mode(mode), .A(A), .B(B),
        .out_valid(vo[1]), .P(P1), .ovf(fo[1])
    );
    dsp_mac_signed_pipe #(.ACC_WIDTH(38), .SATURATE(1'b0)) dut_w (
        .clk(clk), .reset(reset), .in_valid(in_valid), .mode(mode), .A(A), .B(B),
        .out_valid(vo[2]), .P(P2), .ovf(fo[2])
    );
    assign pobs[0] = $signed(P0);
    assign pobs[1] = $signed(P1);
    assign pobs[2] = $signed(P2);
    function automatic longint wrapw(input longint x, input int w);
        return (x <<< (64 - w)) >>> (64 - w);
    endfunction
    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    // Inputs are driven on posedge; a sample driven at posedge k is visible at posedge k+3.
    task automatic step(input logic r, input logic v, input logic [1:0] m, input longint a, input longint b);
        ent_t   e;
        longint p, n, mx, mn;
        @(posedge clk);
        if (sb.size() == 3) begin
            e = sb.pop_front();
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("out_valid[%0d]", i), 64'(vo[i]), 64'(e.v));
                chk($sformatf("P[%0d]", i), pobs[i], $signed(e.p[i]));
                chk($sformatf("ovf[%0d]", i), 64'(fo[i]), 64'(e.o[i]));
            end
        end
        reset = r;
        in_valid = v;
        mode = m;
        A = a[19:0];
        B = b[17:0];
        if (r) begin
            sb.delete();
            repeat (3) sb.push_back('0);
            for (int i = 0; i < 3; i++) begin
                macc[i] = 0;
                movf[i] = 1'b0;
            end
        end else begin
            p = a * b;
            e = '0;
            e.v = v;
            for (int i = 0; i < 3; i++) begin
                if (v) begin
                    mx = (64'sd1 <<< (wid[i] - 1)) - 1;
                    mn = -(64'sd1 <<< (wid[i] - 1));
                    if (m == 2'd0) begin
                        macc[i] = p;
                        movf[i] = 1'b0;
                    end else if (m == 2'd3) begin
                        macc[i] = 0;
                        movf[i] = 1'b0;
                    end else begin
                        n = m == 2'd1 ? macc[i] + p : macc[i] - p;
                        movf[i] = n > mx || n < mn;
                        macc[i] = !movf[i] ? n : sat[i] ? (n > 0 ? mx : mn) : wrapw(n, wid[i]);
                    end
                end
                e.p[i] = macc[i];
                e.o[i] = movf[i];
            end
            sb.push_back(e);
        end
    endtask
    initial begin
        logic [31:0] ra, rb, rm;
        longint      a, b;
        for (int i = 0; i < 3; i++) begin
            macc[i] = 0;
            movf[i] = 1'b0;
        end
        step(1, 1, 0, 5, 2);
        step(1, 1, 0, 5, 2);
        repeat (3) step(0, 0, 0, 0, 0);
        step(0, 1, 0, 5, 2);
        step(0, 1, 0, -524288, -131072);
        step(0, 1, 0, 5, 2);
        step(0, 1, 1, -3, 4);
        step(0, 1, 1, 7, 7);
        step(0, 1, 2, 1, 50);
        step(0, 1, 3, 9, 9);
        step(0, 1, 1, 2, 3);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 1, 1, 4, 4);
        step(0, 1, 0, -524288, -131072);
        step(0, 1, 1, -524288, -131072);
        repeat (3) step(0, 1, 2, -524288, -131072);
        for (int i = 0; i < 32; i++) begin
            ra = $urandom;
            rb = $urandom;
            a = longint'($signed(ra[19:0]));
            b = longint'($signed(rb[17:0]));
            step(i == 20, 1, 0, a, b);
        end
        for (int i = 0; i < 32; i++) begin
            ra = $urandom;
            rb = $urandom;
            rm = $urandom;
            a = longint'($signed(ra[19:0]));
            b = longint'($signed(rb[17:0]));
            step(0, rm[2:0] != 3'd0, rm[4:3], a, b);
        end
        repeat (4) step(0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
